// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: prepends the 14-byte MAC header to a 512b payload stream,
// shifts the payload by 14 bytes and zero-pads single-beat frames to the minimum length.
module eth_tx_framer #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter bit          PAD_EN          = 1'b1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      s_axis_net_tx_tvalid,
  output logic                      s_axis_net_tx_tready,
  input  logic [DATA_WIDTH-1:0]     s_axis_net_tx_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_net_tx_tkeep,
  input  logic                      s_axis_net_tx_tlast,
  output logic                      m_axis_eth_net_tx_tvalid,
  input  logic                      m_axis_eth_net_tx_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_eth_net_tx_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_eth_net_tx_tkeep,
  output logic                      m_axis_eth_net_tx_tlast,
  input  logic [47:0]               local_mac,
  input  logic [47:0]               remote_mac,
  input  logic [15:0]               ethertype,
  output logic                      busy,
  output logic [31:0]               tx_frame_cnt
);

  localparam int unsigned KEEP_W     = DATA_WIDTH / 8;
  localparam int unsigned HDR_BYTES  = 14;
  localparam int unsigned HDR_W      = HDR_BYTES * 8;
  localparam int unsigned BODY_BYTES = KEEP_W - HDR_BYTES;
  localparam int unsigned BODY_W     = BODY_BYTES * 8;
  localparam int unsigned CNT_W      = $clog2(KEEP_W + 1);

  typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

  state_t                state, state_nxt;
  logic [HDR_W-1:0]      carry, carry_nxt;
  logic [CNT_W-1:0]      carry_n, carry_n_nxt;
  logic                  m_valid_nxt, m_last_nxt;
  logic [DATA_WIDTH-1:0] m_data_nxt;
  logic [KEEP_W-1:0]     m_keep_nxt;

  logic [DATA_WIDTH-1:0] s_data_m;
  logic [HDR_W-1:0]      hdr;
  logic [CNT_W-1:0]      s_n;
  logic [CNT_W-1:0]      frame_n;
  logic [CNT_W-1:0]      padded_n;
  logic                  out_free;
  logic                  in_hs;

  // Contiguous byte-enable mask with the low cnt bytes set
  function automatic logic [KEEP_W-1:0] byte_mask(input logic [CNT_W-1:0] cnt);
    logic [KEEP_W-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_W; i++) m[i] = (CNT_W'(i) < cnt);
    return m;
  endfunction

  assign out_free             = !m_axis_eth_net_tx_tvalid || m_axis_eth_net_tx_tready;
  assign s_axis_net_tx_tready = out_free && (state != TAIL);
  assign in_hs                = s_axis_net_tx_tvalid && s_axis_net_tx_tready;
  assign busy                 = (state != IDLE);

  // Input byte masking and header assembly (byte 0 is first on the wire)
  always_comb begin
    s_data_m = '0;
    for (int i = 0; i < KEEP_W; i++)
      s_data_m[8*i +: 8] = s_axis_net_tx_tkeep[i] ? s_axis_net_tx_tdata[8*i +: 8] : 8'h00;
    hdr = '0;
    for (int i = 0; i < 6; i++) begin
      hdr[8*i +: 8]     = remote_mac[8*(5-i) +: 8];
      hdr[8*(6+i) +: 8] = local_mac[8*(5-i) +: 8];
    end
    hdr[96 +: 8]  = ethertype[15:8];
    hdr[104 +: 8] = ethertype[7:0];
  end

  assign s_n      = CNT_W'($countones(s_axis_net_tx_tkeep));
  assign frame_n  = CNT_W'(HDR_BYTES) + s_n;
  assign padded_n = (PAD_EN && (frame_n < CNT_W'(MIN_FRAME_BYTES))) ? CNT_W'(MIN_FRAME_BYTES)
                                                                    : frame_n;

  // Next-state and next output-register contents
  always_comb begin
    state_nxt   = state;
    carry_nxt   = carry;
    carry_n_nxt = carry_n;
    m_valid_nxt = m_axis_eth_net_tx_tvalid;
    m_data_nxt  = m_axis_eth_net_tx_tdata;
    m_keep_nxt  = m_axis_eth_net_tx_tkeep;
    m_last_nxt  = m_axis_eth_net_tx_tlast;

    if (out_free) begin
      m_valid_nxt = 1'b0;
      m_data_nxt  = '0;
      m_keep_nxt  = '0;
      m_last_nxt  = 1'b0;
    end

    case (state)
      IDLE, BODY: begin
        if (in_hs) begin
          m_valid_nxt = 1'b1;
          m_data_nxt  = {s_data_m[BODY_W-1:0], (state == IDLE) ? hdr : carry};
          carry_nxt   = s_data_m[DATA_WIDTH-1 -: HDR_W];
          if (!s_axis_net_tx_tlast) begin
            m_keep_nxt = '1;
            m_last_nxt = 1'b0;
            state_nxt  = BODY;
          end else if (s_n <= CNT_W'(BODY_BYTES)) begin
            // Only a frame that fits in one output beat can be short enough to pad
            m_keep_nxt = byte_mask((state == IDLE) ? padded_n : frame_n);
            m_last_nxt = 1'b1;
            state_nxt  = IDLE;
          end else begin
            m_keep_nxt  = '1;
            m_last_nxt  = 1'b0;
            carry_n_nxt = s_n - CNT_W'(BODY_BYTES);
            state_nxt   = TAIL;
          end
        end
      end
      TAIL: begin
        if (out_free) begin
          m_valid_nxt = 1'b1;
          m_data_nxt  = {{(DATA_WIDTH-HDR_W){1'b0}}, carry};
          m_keep_nxt  = byte_mask(carry_n);
          m_last_nxt  = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state                    <= IDLE;
      carry                    <= '0;
      carry_n                  <= '0;
      m_axis_eth_net_tx_tvalid <= 1'b0;
      m_axis_eth_net_tx_tdata  <= '0;
      m_axis_eth_net_tx_tkeep  <= '0;
      m_axis_eth_net_tx_tlast  <= 1'b0;
    end else begin
      state                    <= state_nxt;
      carry                    <= carry_nxt;
      carry_n                  <= carry_n_nxt;
      m_axis_eth_net_tx_tvalid <= m_valid_nxt;
      m_axis_eth_net_tx_tdata  <= m_data_nxt;
      m_axis_eth_net_tx_tkeep  <= m_keep_nxt;
      m_axis_eth_net_tx_tlast  <= m_last_nxt;
    end
  end

  // Completed-frame counter, free-running wrap
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tx_frame_cnt <= '0;
    end else if (m_axis_eth_net_tx_tvalid && m_axis_eth_net_tx_tready && m_axis_eth_net_tx_tlast) begin
      tx_frame_cnt <= tx_frame_cnt + 32'd1;
    end
  end

endmodule
